// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache, bundled for a single port.
// The cache uses the slave modport; the environment driving it uses master.
interface data_cache_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic                     cpu_re;
    logic [3:0]               cpu_we;
    logic [DATA_WIDTH-1:0]    cpu_wdata;
    logic [DATA_WIDTH-1:0]    cpu_rdata;
    logic                     stall;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [3:0]               mem_be;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        output cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_ready, mem_rdata,
        input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        input  cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_ready, mem_rdata,
        output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache. Read hits are
// served combinationally; misses refill a full line one word per memory beat.
module data_cache #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    data_cache_if.slave bus
);
    localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int LINE_LSB   = 2 + WORD_BITS;
    localparam int TAG_LSB    = LINE_LSB + INDEX_BITS;
    localparam int TAG_BITS   = ADDRESS_WIDTH - TAG_LSB;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

    state_t                   state_q;
    logic [WORD_BITS-1:0]     count_q;
    logic [SETS-1:0]          valid_q;
    logic [TAG_BITS-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0]    data_q [SETS][WORDS_PER_LINE];

    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [3:0]               mem_be_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;

    logic [WORD_BITS-1:0]              word_sel;
    logic [INDEX_BITS-1:0]             index;
    logic [TAG_BITS-1:0]               addr_tag;
    logic [ADDRESS_WIDTH-LINE_LSB-1:0] line_addr;
    logic [WORD_BITS-1:0]              count_inc;
    logic                              hit;
    logic                              store_req;
    logic                              read_miss;
    logic                              refill_beat;
    logic                              store_hit_beat;
    logic [DATA_WIDTH-1:0]             cur_word;
    logic [DATA_WIDTH-1:0]             merged_d;
    logic                              unused_offset;

    assign word_sel  = bus.cpu_addr[2 +: WORD_BITS];
    assign index     = bus.cpu_addr[LINE_LSB +: INDEX_BITS];
    assign addr_tag  = bus.cpu_addr[TAG_LSB +: TAG_BITS];
    assign line_addr = bus.cpu_addr[ADDRESS_WIDTH-1:LINE_LSB];
    assign count_inc = count_q + WORD_BITS'(1);
    assign unused_offset = ^bus.cpu_addr[1:0];

    assign hit       = valid_q[index] && (tag_q[index] == addr_tag);
    assign store_req = |bus.cpu_we;
    assign read_miss = bus.cpu_re && !hit;
    assign cur_word  = data_q[index][word_sel];

    assign refill_beat    = !rst && (state_q == REFILL) && bus.mem_ready;
    assign store_hit_beat = !rst && (state_q == WRITE) && bus.mem_ready && hit;

    // Byte-lane merge of a store into the currently cached word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged_d[8*gi +: 8] = bus.cpu_we[gi] ? bus.cpu_wdata[8*gi +: 8]
                                                     : cur_word[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store_req) begin
                        state_q     <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {bus.cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_be_q    <= bus.cpu_we;
                        mem_wdata_q <= bus.cpu_wdata;
                    end else if (read_miss) begin
                        // Invalidate first so a half-filled line can never hit.
                        state_q        <= REFILL;
                        count_q        <= '0;
                        valid_q[index] <= 1'b0;
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= 1'b0;
                        mem_addr_q     <= {line_addr, {WORD_BITS{1'b0}}, 2'b00};
                        mem_be_q       <= 4'hF;
                    end
                end
                REFILL: begin
                    if (bus.mem_ready) begin
                        count_q    <= count_inc;
                        mem_addr_q <= {line_addr, count_inc, 2'b00};
                        if (count_q == LAST_BEAT) begin
                            valid_q[index] <= 1'b1;
                            mem_req_q      <= 1'b0;
                            state_q        <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (refill_beat) begin
            data_q[index][count_q] <= bus.mem_rdata;
            if (count_q == LAST_BEAT) begin
                tag_q[index] <= addr_tag;
            end
        end else if (store_hit_beat) begin
            data_q[index][word_sel] <= merged_d;
        end
    end

    assign bus.stall = ((state_q == IDLE) && (store_req || read_miss))
                     || (state_q == REFILL) || (state_q == WRITE);
    assign bus.cpu_rdata = cur_word;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a transaction-level cache/memory model predicts
// stall length, memory beats and read data; a per-cycle process checks read data.
module tb_data_cache;
    logic clk;
    logic rst;

    data_cache_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_cache #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(16), .WORDS_PER_LINE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] mem [logic [31:0]];
    int          wait_cycles = 0;

    // Model of the cache contents: which line address each set currently holds.
    bit          m_valid [16];
    logic [31:0] m_line  [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return w ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] nw);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Backing memory: mem_ready after wait_cycles idle cycles of each beat.
    initial begin
        int wait_cnt;
        wait_cnt      = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !rst) begin
                if (wait_cnt >= wait_cycles) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_rd(bus.mem_addr);
                    beats.push_back('{bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata});
                    wait_cnt = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
                wait_cnt      = 0;
            end
        end
    end

    // A write-through cache must always return what backing memory holds.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.cpu_re && !bus.stall)
                chk("rdata vs memory", bus.cpu_rdata, mem_rd(bus.cpu_addr));
            if (!rst && bus.mem_req && !bus.mem_we)
                chk("refill mem_be", 32'(bus.mem_be), 32'hF);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        summary_and_finish();
    end

    task automatic do_op(input string name, input bit is_store, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata, input int waits,
                         output int stall_cnt, output logic [31:0] rdata);
        int          idx;
        bit          hit;
        int          exp_stall;
        int          exp_n;
        bit          done;
        logic [31:0] line_base;
        idx       = int'(addr[7:4]);
        line_base = {addr[31:4], 4'h0};
        hit       = m_valid[idx] && (m_line[idx] == line_base);
        if (is_store) begin
            exp_stall = 2 + waits;
            exp_n     = 1;
        end else if (hit) begin
            exp_stall = 0;
            exp_n     = 0;
        end else begin
            exp_stall = 1 + 4 * (1 + waits);
            exp_n     = 4;
        end
        beats.delete();
        wait_cycles   = waits;
        bus.cpu_addr  = addr;
        bus.cpu_re    = !is_store;
        bus.cpu_we    = is_store ? be : 4'h0;
        bus.cpu_wdata = wdata;
        stall_cnt = 0;
        done      = 1'b0;
        rdata     = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus.stall) begin
                done  = 1'b1;
                rdata = bus.cpu_rdata;
                break;
            end
            stall_cnt++;
        end
        if (!done) begin
            $display("FAIL %s timeout: got stall stuck expected release", name);
            errors++;
            summary_and_finish();
        end
        @(posedge clk);
        #1;
        bus.cpu_re = 1'b0;
        bus.cpu_we = 4'h0;
        chk({name, " stall"}, 32'(stall_cnt), 32'(exp_stall));
        chk({name, " beats"}, 32'(beats.size()), 32'(exp_n));
        for (int i = 0; i < beats.size() && i < exp_n; i++) begin
            if (is_store) begin
                chk({name, " wr addr"},  beats[i].addr, {addr[31:2], 2'b00});
                chk({name, " wr we"},    32'(beats[i].we), 32'd1);
                chk({name, " wr be"},    32'(beats[i].be), 32'(be));
                chk({name, " wr wdata"}, beats[i].wdata, wdata);
            end else begin
                chk({name, " rd addr"}, beats[i].addr, line_base + 32'(4 * i));
                chk({name, " rd we"},   32'(beats[i].we), 32'd0);
            end
        end
        if (is_store) begin
            mem[{addr[31:2], 2'b00}] = merge(mem_rd(addr), be, wdata);
        end else if (!hit) begin
            m_valid[idx] = 1'b1;
            m_line[idx]  = line_base;
        end
        $display("txn %-14s addr=%h hit=%0d stall=%0d beats=%0d rdata=%h",
                 name, addr, hit, stall_cnt, beats.size(), rdata);
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        rst           = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_re    = 1'b0;
        bus.cpu_we    = 4'h0;
        bus.cpu_wdata = '0;
        mem[32'h40] = 32'h11;
        mem[32'h44] = 32'h22;
        mem[32'h48] = 32'h33;
        mem[32'h4C] = 32'h44;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset stall",   32'(bus.stall),   32'd0);
        chk("reset mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1;

        do_op("rd 0x40 miss", 1'b0, 32'h40, 4'h0, '0, 0, st, rd);
        chk("lit rd 0x40 data", rd, 32'h11);
        chk("lit rd 0x40 stall", 32'(st), 32'd5);
        do_op("rd 0x48 hit", 1'b0, 32'h48, 4'h0, '0, 0, st, rd);
        chk("lit rd 0x48 data", rd, 32'h33);
        chk("lit rd 0x48 stall", 32'(st), 32'd0);
        do_op("st 0x44 hit", 1'b1, 32'h44, 4'b0011, 32'hAAAA_BBBB, 0, st, rd);
        chk("lit st stall", 32'(st), 32'd2);
        do_op("rd 0x44 hit", 1'b0, 32'h44, 4'h0, '0, 0, st, rd);
        chk("lit merged word", rd, 32'h0000_BBBB);
        do_op("st 0x1000 miss", 1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, 0, st, rd);
        do_op("rd 0x1000 miss", 1'b0, 32'h1000, 4'h0, '0, 0, st, rd);
        chk("lit no-allocate", 32'(st), 32'd5);
        chk("lit rd 0x1000 data", rd, 32'hCAFE_F00D);
        do_op("rd 0x140 conf", 1'b0, 32'h140, 4'h0, '0, 0, st, rd);
        do_op("rd 0x40 conf", 1'b0, 32'h40, 4'h0, '0, 0, st, rd);
        chk("lit conflict data", rd, 32'h11);
        chk("lit conflict stall", 32'(st), 32'd5);
        do_op("st 0x4F w2", 1'b1, 32'h4F, 4'b1000, 32'h9900_0000, 2, st, rd);
        do_op("rd 0x4C hit", 1'b0, 32'h4C, 4'h0, '0, 0, st, rd);
        chk("lit byte3 store", rd, 32'h9900_0044);
        do_op("rd 0x184 w1", 1'b0, 32'h184, 4'h0, '0, 1, st, rd);
        chk("lit wait1 stall", 32'(st), 32'd9);

        // Abandon a slow refill with reset part-way through.
        beats.delete();
        wait_cycles  = 3;
        bus.cpu_addr = 32'h240;
        bus.cpu_re   = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort stalled", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.cpu_re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        chk("abort mem_req", 32'(bus.mem_req), 32'd0);
        chk("abort stall",   32'(bus.stall),   32'd0);
        chk("abort beats",   32'(beats.size()), 32'd1);
        $display("txn %-14s addr=%h beats_before_reset=%0d", "rst mid-refill", 32'h240, beats.size());
        @(posedge clk);
        #1;
        do_op("rd 0x240 w3", 1'b0, 32'h240, 4'h0, '0, 3, st, rd);
        chk("lit refill after rst", 32'(st), 32'd17);
        do_op("rd 0x240 hit", 1'b0, 32'h240, 4'h0, '0, 0, st, rd);
        do_op("rd 0x44 post", 1'b0, 32'h44, 4'h0, '0, 0, st, rd);
        chk("lit post-rst data", rd, 32'h0000_BBBB);
        chk("lit post-rst stall", 32'(st), 32'd5);

        summary_and_finish();
    end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and a slower backing data memory. Reads that hit return data in the same cycle. Misses and all stores stall the CPU through a single-outstanding-request handshake on the memory side. Read misses refill a whole line, one word per beat.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte address width on both sides
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes)
- SETS, 16, number of lines; power of two ≥ 2
- WORDS_PER_LINE, 4, words per line; power of two ≥ 2

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cpu_addr  in  ADDRESS_WIDTH  byte address from memory stage; bits [1:0] ignored
- cpu_re  in  1  load request
- cpu_we  in  4  store byte enables; non-zero means store
- cpu_wdata  in  DATA_WIDTH  store data, lane-aligned
- cpu_rdata  out  DATA_WIDTH  full addressed word; valid when cpu_re && !stall
- stall  out  1  CPU must hold all cpu_* inputs stable while high
- mem_req  out  1  backing-memory request; held until accepted
- mem_we  out  1  1 = store beat, 0 = refill read beat
- mem_addr  out  ADDRESS_WIDTH  word-aligned beat address
- mem_be  out  4  byte enables for stores (copy of cpu_we); 4'hF on reads
- mem_wdata  out  DATA_WIDTH  store data (copy of cpu_wdata)
- mem_ready  in  1  one-cycle accept/complete pulse; read data valid in the same cycle
- mem_rdata  in  DATA_WIDTH  refill word

## Operation
- Address split: offset [1:0]; word select next log2(WORDS_PER_LINE) bits; index next log2(SETS) bits; tag = remaining upper bits. Defaults: word [3:2], index [7:4], tag [31:8].
- Storage: per line, one valid bit, one tag and WORDS_PER_LINE data words, in flops. rst clears every valid bit. Tags and data are not reset.
- hit = valid[index] && tag[index] == addr tag.
- FSM states: IDLE, REFILL, WRITE, RESP.
- IDLE:
  - cpu_we != 0 → WRITE. Stores take priority over cpu_re.
  - Else cpu_re && !hit → REFILL, beat counter = 0.
  - Else stay in IDLE; read hits are served combinationally.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = line base + 4·counter.
  - Each mem_ready writes mem_rdata into word[counter] and increments counter.
  - On the final beat, write tag, set valid and go to RESP.
  - valid stays 0 during the refill, so a partially filled line never reads as a hit.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = cpu_addr with [1:0] cleared.
  - On mem_ready: if hit, merge the enabled bytes into the cached word; then go to RESP.
  - A store miss does not allocate and leaves the cache unchanged.
- RESP: one cycle with stall=0, and cpu_rdata comes from the array; the line now hits after a refill. Next state is always IDLE, and no new request is evaluated in this cycle.
- stall = (state==IDLE && (cpu_we!=0 || (cpu_re && !hit))) || state==REFILL || state==WRITE.
- mem_req=0 in IDLE and RESP. mem_addr, mem_be, mem_wdata and mem_we are don't-care while mem_req=0.

## Timing
- Reset values: state IDLE, mem_req 0, stall 0 (with no request), counter 0, all valid bits 0.
- Read hit: 0-cycle latency; stall low.
- mem_ready may assert in the first cycle mem_req is high.
- Read miss with zero-wait memory: stall high for 1 + WORDS_PER_LINE cycles (5 by default), then low in RESP with correct data. Each memory wait cycle adds one stall cycle.
- Store with zero-wait memory: stall high for 2 cycles, then RESP.
- Counter wraps to 0 after the last beat.
- mem_ready while mem_req=0 is ignored.
- rst during REFILL or WRITE: state goes to IDLE and mem_req drops at that edge; the line being refilled stays invalid. Backing memory must tolerate an abandoned request.
- Refill always starts at word 0 of the line (no critical-word-first).

## Test plan
- Reset, then cpu_re at 0x40 with memory words 0x40..0x4C = 0x11, 0x22, 0x33, 0x44, zero-wait → mem_req seen at 0x40, 0x44, 0x48, 0x4C; stall high 5 cycles; cpu_rdata = 0x11 in RESP.
- Following cpu_re at 0x48 → hit; stall never high; cpu_rdata = 0x33; no mem_req.
- Store cpu_we=4'b0011, wdata 0xAAAABBBB at 0x44 (hit) → one mem_req with mem_we=1, mem_be=0011; a later read at 0x44 returns 0x0000BBBB with upper bytes from 0x22.
- Store to 0x1000 (miss) → memory written; a read at 0x1000 then misses and refills; no allocation on the store.
- Conflict: read 0x40, then 0x140 (same index, different tag), then 0x40 → three refills; the final read returns the original 0x11.
- Memory with 3 wait cycles per beat, rst asserted mid-refill → mem_req low the next cycle; state IDLE; a re-read of the same address performs a full 4-beat refill.
